// File: rtl/pwm_decoder.sv
// pwm_decoder: measures the high time, period and quantized duty (0..3) of an
// asynchronous PWM line, and flags loss of signal when no edge arrives for
// TIMEOUT cycles. The receive-side counterpart of the PWM generator.
//
// Handshake: meas_valid is a one-cycle strobe. high_time/period/duty are valid
// in the strobe cycle and hold their values until the next strobe.
// The consumer has no ready input and cannot stall the decoder.
module pwm_decoder #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic             clk,
  input  logic             rst_a,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] period,
  output logic [1:0]       duty,
  output logic             meas_valid,
  output logic             no_signal,
  output logic             stuck_level
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] AGE_MAX = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_age;
  logic [CNT_W-1:0] r_hcap;
  logic [CNT_W-1:0] r_high_time;
  logic [CNT_W-1:0] r_period;
  logic [1:0]       r_duty;
  logic             r_meas_valid;
  logic             r_no_signal;
  logic             r_stuck_level;

  logic             w_rise;
  logic             w_fall;
  logic             w_edge;
  logic             w_timeout;
  logic             w_capture;
  logic             w_emit;
  logic [CNT_W+1:0] w_h4;
  logic [CNT_W+1:0] w_p1;
  logic [CNT_W+1:0] w_p2;
  logic [CNT_W+1:0] w_p3;
  logic [1:0]       w_duty;

  // Edge detection on the synchronized line; an edge that lands in the same
  // cycle the age counter reaches TIMEOUT suppresses the timeout.
  assign w_rise    = r_s2 & ~r_s3;
  assign w_fall    = ~r_s2 & r_s3;
  assign w_edge    = w_rise | w_fall;
  assign w_timeout = (r_age == AGE_MAX) && !w_edge;

  // Two-flop synchronizer plus one delay stage for edge detection.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= pwm_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and datapath strobes; timeout overrides every state.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_emit      = 1'b0;
    if (w_timeout) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: if (w_rise) w_state_nxt = HIGH;
        HIGH: if (w_fall) begin
          w_state_nxt = LOW;
          w_capture   = 1'b1;
        end
        LOW:  if (w_rise) begin
          w_state_nxt = HIGH;
          w_emit      = 1'b1;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Duty quantization: compare 4h against p, 2p and 3p in CNT_W+2 bits so the
  // products never overflow.
  always_comb begin
    w_h4   = {r_hcap, 2'b00};
    w_p1   = {2'b00, r_cnt};
    w_p2   = {1'b0, r_cnt, 1'b0};
    w_p3   = w_p1 + w_p2;
    w_duty = 2'd0;
    if      (w_h4 >= w_p3) w_duty = 2'd3;
    else if (w_h4 >= w_p2) w_duty = 2'd2;
    else if (w_h4 >= w_p1) w_duty = 2'd1;
  end

  // Period counter restarts on each rise; edge-age counter on any edge. Both saturate.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      r_cnt <= '0;
      r_age <= '0;
    end else begin
      if (w_rise)                r_cnt <= ONE;
      else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + ONE;
      if (w_edge)                r_age <= ONE;
      else if (r_age != AGE_MAX) r_age <= r_age + ONE;
    end
  end

  // Measurement capture, result registers and loss-of-signal flags.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      r_hcap        <= '0;
      r_high_time   <= '0;
      r_period      <= '0;
      r_duty        <= 2'd0;
      r_meas_valid  <= 1'b0;
      r_no_signal   <= 1'b0;
      r_stuck_level <= 1'b0;
    end else begin
      r_meas_valid <= w_emit;
      if (w_capture) r_hcap <= r_cnt;
      if (w_emit) begin
        r_high_time <= r_hcap;
        r_period    <= r_cnt;
        r_duty      <= w_duty;
        r_no_signal <= 1'b0;
      end
      if (w_timeout) begin
        r_no_signal   <= 1'b1;
        r_stuck_level <= r_s2;
      end
    end
  end

  assign high_time   = r_high_time;
  assign period      = r_period;
  assign duty        = r_duty;
  assign meas_valid  = r_meas_valid;
  assign no_signal   = r_no_signal;
  assign stuck_level = r_stuck_level;

endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder: directed checks of pwm_decoder with a clk-synchronous PWM
// stimulus and hand-computed expected measurements.
module tb_pwm_decoder;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 200;

  logic             clk = 1'b0;
  logic             rst_a = 1'b1;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] high_time;
  logic [CNT_W-1:0] period;
  logic [1:0]       duty;
  logic             meas_valid;
  logic             no_signal;
  logic             stuck_level;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int ns_cycles   = 0;
  logic prev_ns   = 1'b0;

  int               got_cyc[$];
  logic [CNT_W-1:0] got_ht[$];
  logic [CNT_W-1:0] got_per[$];
  logic [1:0]       got_duty[$];
  logic             got_ns[$];
  logic             got_prev_ns[$];
  int               rise_cyc[$];

  pwm_decoder #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_a       (rst_a),
    .pwm_in      (pwm_in),
    .high_time   (high_time),
    .period      (period),
    .duty        (duty),
    .meas_valid  (meas_valid),
    .no_signal   (no_signal),
    .stuck_level (stuck_level)
  );

  // Clock and cycle counter (cyc == number of rising edges seen so far).
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record every measurement strobe and track no_signal history.
  always @(negedge clk) begin
    if (meas_valid === 1'b1) begin
      got_cyc.push_back(cyc);
      got_ht.push_back(high_time);
      got_per.push_back(period);
      got_duty.push_back(duty);
      got_ns.push_back(no_signal);
      got_prev_ns.push_back(prev_ns);
    end
    if (no_signal === 1'b1) ns_cycles <= ns_cycles + 1;
    prev_ns <= no_signal;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    got_cyc.delete();
    got_ht.delete();
    got_per.delete();
    got_duty.delete();
    got_ns.delete();
    got_prev_ns.delete();
    rise_cyc.delete();
  endtask

  // n periods of h high / l low, then a closing rise (4 high, 2 low) so the
  // last full period gets reported. With flush, records from the first period
  // (which reports whatever preceded the task) are dropped.
  task automatic run_wave(input int h, input int l, input int n, input bit flush);
    for (int i = 0; i < n; i++) begin
      pwm_in = 1'b1;
      rise_cyc.push_back(cyc);
      tick(h);
      pwm_in = 1'b0;
      tick(l);
      if (flush && i == 0) clear_all();
    end
    pwm_in = 1'b1;
    rise_cyc.push_back(cyc);
    tick(4);
    pwm_in = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    #2 rst_a = 1'b0;
    tick(3);
    vectors++; if (high_time !== '0) begin miscompares++; $display("FAIL reset_high_time: got %0d expected 0", high_time); end
    vectors++; if (period !== '0) begin miscompares++; $display("FAIL reset_period: got %0d expected 0", period); end
    vectors++; if (duty !== 2'd0) begin miscompares++; $display("FAIL reset_duty: got %0d expected 0", duty); end
    vectors++; if (meas_valid !== 1'b0) begin miscompares++; $display("FAIL reset_meas_valid: got %b expected 0", meas_valid); end
    vectors++; if (no_signal !== 1'b0) begin miscompares++; $display("FAIL reset_no_signal: got %b expected 0", no_signal); end
    vectors++; if (stuck_level !== 1'b0) begin miscompares++; $display("FAIL reset_stuck_level: got %b expected 0", stuck_level); end
    rst_a = 1'b1;
    tick(2);
  endtask

  // 25/75: first rise silent, then four reports of 25/100/duty 1.
  task automatic test_quarter();
    clear_all();
    run_wave(25, 75, 4, 1'b0);
    void'(rise_cyc.pop_front());
    vectors++; if (got_ht.size() != 4) begin miscompares++; $display("FAIL quarter_count: got %0d expected 4", got_ht.size()); end
    for (int i = 0; i < got_ht.size() && i < rise_cyc.size(); i++) begin
      vectors++; if (got_ht[i] !== CNT_W'(25)) begin miscompares++; $display("FAIL quarter_ht[%0d]: got %0d expected 25", i, got_ht[i]); end
      vectors++; if (got_per[i] !== CNT_W'(100)) begin miscompares++; $display("FAIL quarter_per[%0d]: got %0d expected 100", i, got_per[i]); end
      vectors++; if (got_duty[i] !== 2'd1) begin miscompares++; $display("FAIL quarter_duty[%0d]: got %0d expected 1", i, got_duty[i]); end
      vectors++; if (got_cyc[i] != rise_cyc[i] + 3) begin miscompares++; $display("FAIL quarter_latency[%0d]: got cycle %0d expected %0d", i, got_cyc[i], rise_cyc[i] + 3); end
    end
  endtask

  // Period 100 with high 50, 75, 99 -> duty 2, 3, 3.
  task automatic test_duty_sweep();
    int hs[3];
    logic [1:0] ds[3];
    hs[0] = 50; hs[1] = 75; hs[2] = 99;
    ds[0] = 2'd2; ds[1] = 2'd3; ds[2] = 2'd3;
    for (int k = 0; k < 3; k++) begin
      clear_all();
      run_wave(hs[k], 100 - hs[k], 2, 1'b1);
      vectors++; if (got_ht.size() != 2) begin miscompares++; $display("FAIL sweep%0d_count: got %0d expected 2", hs[k], got_ht.size()); end
      for (int i = 0; i < got_ht.size(); i++) begin
        vectors++; if (got_ht[i] !== CNT_W'(hs[k])) begin miscompares++; $display("FAIL sweep%0d_ht[%0d]: got %0d expected %0d", hs[k], i, got_ht[i], hs[k]); end
        vectors++; if (got_per[i] !== CNT_W'(100)) begin miscompares++; $display("FAIL sweep%0d_per[%0d]: got %0d expected 100", hs[k], i, got_per[i]); end
        vectors++; if (got_duty[i] !== ds[k]) begin miscompares++; $display("FAIL sweep%0d_duty[%0d]: got %0d expected %0d", hs[k], i, got_duty[i], ds[k]); end
      end
    end
  endtask

  // Narrowest pulse: 1 high / 9 low, one strobe per period at rise + 3.
  task automatic test_narrow();
    clear_all();
    run_wave(1, 9, 4, 1'b1);
    vectors++; if (got_ht.size() != 4) begin miscompares++; $display("FAIL narrow_count: got %0d expected 4", got_ht.size()); end
    for (int i = 0; i < got_ht.size() && i < rise_cyc.size(); i++) begin
      vectors++; if (got_ht[i] !== CNT_W'(1)) begin miscompares++; $display("FAIL narrow_ht[%0d]: got %0d expected 1", i, got_ht[i]); end
      vectors++; if (got_per[i] !== CNT_W'(10)) begin miscompares++; $display("FAIL narrow_per[%0d]: got %0d expected 10", i, got_per[i]); end
      vectors++; if (got_duty[i] !== 2'd0) begin miscompares++; $display("FAIL narrow_duty[%0d]: got %0d expected 0", i, got_duty[i]); end
      vectors++; if (got_cyc[i] != rise_cyc[i] + 3) begin miscompares++; $display("FAIL narrow_latency[%0d]: got cycle %0d expected %0d", i, got_cyc[i], rise_cyc[i] + 3); end
    end
  endtask

  // Hold high: no_signal exactly TIMEOUT cycles after the registered rise,
  // outputs keep the last report (4 high / 6 period / duty 2 from the closing
  // pulse), then a 30/70 restart clears no_signal on its first report.
  task automatic test_timeout();
    int c;
    clear_all();
    pwm_in = 1'b1;
    c = cyc;
    tick(TIMEOUT + 2);
    vectors++; if (no_signal !== 1'b0) begin miscompares++; $display("FAIL timeout_early: got %b expected 0 at cycle %0d", no_signal, cyc - c); end
    tick(1);
    vectors++; if (no_signal !== 1'b1) begin miscompares++; $display("FAIL timeout_assert: got %b expected 1 at cycle %0d", no_signal, cyc - c); end
    vectors++; if (stuck_level !== 1'b1) begin miscompares++; $display("FAIL timeout_stuck: got %b expected 1", stuck_level); end
    tick(20);
    vectors++; if (no_signal !== 1'b1) begin miscompares++; $display("FAIL timeout_hold_ns: got %b expected 1", no_signal); end
    vectors++; if (high_time !== CNT_W'(4)) begin miscompares++; $display("FAIL timeout_hold_ht: got %0d expected 4", high_time); end
    vectors++; if (period !== CNT_W'(6)) begin miscompares++; $display("FAIL timeout_hold_per: got %0d expected 6", period); end
    vectors++; if (duty !== 2'd2) begin miscompares++; $display("FAIL timeout_hold_duty: got %0d expected 2", duty); end
    pwm_in = 1'b0;
    tick(70);
    clear_all();
    run_wave(30, 70, 3, 1'b0);
    void'(rise_cyc.pop_front());
    vectors++; if (got_ht.size() != 3) begin miscompares++; $display("FAIL restart_count: got %0d expected 3", got_ht.size()); end
    if (got_ht.size() > 0) begin
      vectors++; if (got_prev_ns[0] !== 1'b1) begin miscompares++; $display("FAIL restart_ns_before: got %b expected 1", got_prev_ns[0]); end
      vectors++; if (got_ns[0] !== 1'b0) begin miscompares++; $display("FAIL restart_ns_clear: got %b expected 0", got_ns[0]); end
    end
    for (int i = 0; i < got_ht.size(); i++) begin
      vectors++; if (got_ht[i] !== CNT_W'(30)) begin miscompares++; $display("FAIL restart_ht[%0d]: got %0d expected 30", i, got_ht[i]); end
      vectors++; if (got_per[i] !== CNT_W'(100)) begin miscompares++; $display("FAIL restart_per[%0d]: got %0d expected 100", i, got_per[i]); end
      vectors++; if (got_duty[i] !== 2'd1) begin miscompares++; $display("FAIL restart_duty[%0d]: got %0d expected 1", i, got_duty[i]); end
    end
  endtask

  // High phase exactly TIMEOUT long: the fall wins, no timeout, 200/250/3.
  task automatic test_edge_at_timeout();
    int base;
    base = ns_cycles;
    clear_all();
    run_wave(TIMEOUT, 50, 2, 1'b1);
    vectors++; if (ns_cycles != base) begin miscompares++; $display("FAIL edge_tmo_ns: got %0d no_signal cycles expected 0", ns_cycles - base); end
    vectors++; if (got_ht.size() != 2) begin miscompares++; $display("FAIL edge_tmo_count: got %0d expected 2", got_ht.size()); end
    for (int i = 0; i < got_ht.size(); i++) begin
      vectors++; if (got_ht[i] !== CNT_W'(TIMEOUT)) begin miscompares++; $display("FAIL edge_tmo_ht[%0d]: got %0d expected %0d", i, got_ht[i], TIMEOUT); end
      vectors++; if (got_per[i] !== CNT_W'(TIMEOUT + 50)) begin miscompares++; $display("FAIL edge_tmo_per[%0d]: got %0d expected %0d", i, got_per[i], TIMEOUT + 50); end
      vectors++; if (got_duty[i] !== 2'd3) begin miscompares++; $display("FAIL edge_tmo_duty[%0d]: got %0d expected 3", i, got_duty[i]); end
    end
  endtask

  // Reset late in a 30-cycle high phase for 3 cycles; the line falls while
  // reset is held. Outputs clear at once, next rise is silent, then 30/100/1.
  task automatic test_reset_mid_high();
    pwm_in = 1'b1;
    tick(28);
    rst_a = 1'b0;
    #1;
    vectors++; if (high_time !== '0) begin miscompares++; $display("FAIL rst_mid_ht: got %0d expected 0", high_time); end
    vectors++; if (period !== '0) begin miscompares++; $display("FAIL rst_mid_per: got %0d expected 0", period); end
    vectors++; if (duty !== 2'd0) begin miscompares++; $display("FAIL rst_mid_duty: got %0d expected 0", duty); end
    vectors++; if (meas_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_mv: got %b expected 0", meas_valid); end
    vectors++; if (no_signal !== 1'b0) begin miscompares++; $display("FAIL rst_mid_ns: got %b expected 0", no_signal); end
    vectors++; if (stuck_level !== 1'b0) begin miscompares++; $display("FAIL rst_mid_stuck: got %b expected 0", stuck_level); end
    tick(2);
    pwm_in = 1'b0;
    tick(1);
    rst_a = 1'b1;
    tick(68);
    clear_all();
    run_wave(30, 70, 3, 1'b0);
    void'(rise_cyc.pop_front());
    vectors++; if (got_ht.size() != 3) begin miscompares++; $display("FAIL rst_mid_count: got %0d expected 3", got_ht.size()); end
    for (int i = 0; i < got_ht.size() && i < rise_cyc.size(); i++) begin
      vectors++; if (got_ht[i] !== CNT_W'(30)) begin miscompares++; $display("FAIL rst_mid_ht[%0d]: got %0d expected 30", i, got_ht[i]); end
      vectors++; if (got_per[i] !== CNT_W'(100)) begin miscompares++; $display("FAIL rst_mid_per[%0d]: got %0d expected 100", i, got_per[i]); end
      vectors++; if (got_duty[i] !== 2'd1) begin miscompares++; $display("FAIL rst_mid_duty[%0d]: got %0d expected 1", i, got_duty[i]); end
      vectors++; if (got_cyc[i] != rise_cyc[i] + 3) begin miscompares++; $display("FAIL rst_mid_latency[%0d]: got cycle %0d expected %0d", i, got_cyc[i], rise_cyc[i] + 3); end
    end
  endtask

  // Watchdog: the sequence is bounded, but never let a run hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_quarter();
    test_duty_sweep();
    test_narrow();
    test_timeout();
    test_edge_at_timeout();
    test_reset_mid_high();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
